// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency 4-bit signed
// sequential multiplier between N requesters. Each requester gets a
// one-cycle operand grant and later a one-cycle tagged result strobe.
module mul_share_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [4*N-1:0]   a_bus,
    input  logic [4*N-1:0]   b_bus,
    output logic [N-1:0]     gnt,
    output logic             rsp_valid,
    output logic [1:0]       rsp_id,
    output logic [7:0]       rsp_p,
    output logic             busy,
    output logic             mul_start,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p
);

    localparam int unsigned IdW  = $clog2(N);
    localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   last_q;
    logic [IdW-1:0]   id_q;
    logic [CntW-1:0]  cnt_q;
    logic [IdW-1:0]   cand;
    logic [IdW-1:0]   win_idx;
    logic             win_found;
    logic             grant;

    // Round-robin search: first requesting index strictly after last_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= int'(N); k++) begin
            cand = last_q + IdW'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic and the combinational grant pulse.
    always_comb begin
        state_d = state_q;
        gnt     = '0;
        grant   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // No grant while reset is asserted: the operands would not be latched.
                if (win_found && !rst) begin
                    grant        = 1'b1;
                    gnt[win_idx] = 1'b1;
                    state_d      = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (cnt_q == CntW'(MUL_LAT - 1)) begin
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
        endcase
    end

    // State register, operand/id capture, latency counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= IdW'(N - 1);
            id_q    <= '0;
            cnt_q   <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            rsp_id  <= '0;
            rsp_p   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                mul_a  <= a_bus[4*win_idx +: 4];
                mul_b  <= b_bus[4*win_idx +: 4];
                id_q   <= win_idx;
                last_q <= win_idx;
            end
            if (state_q == StIssue) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            // The multiplier output is first valid in the last WAIT cycle.
            if (state_q == StWait && cnt_q == CntW'(MUL_LAT - 1)) begin
                rsp_p  <= mul_p;
                rsp_id <= id_q;
            end
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        mul_start = (state_q == StIssue);
        rsp_valid = (state_q == StResp);
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural 5-cycle signed
// multiplier model attached to the mul_* port.
module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a_bus;
    logic [15:0] b_bus;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_p;
    logic        busy;
    logic        mul_start;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_g = 0;

    int viol_gnt = 0;
    int viol_rsp = 0;
    int start_cnt = 0;
    int gnt3_cnt = 0;
    int rsp_cnt = 0;
    logic [7:0] last_p = 8'h0;
    logic prev_rsp = 1'b0;

    mul_share_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: start sampled at edge, p valid 5 cycles after the start cycle.
    logic [2:0]        m_cnt = 3'd0;
    logic signed [7:0] m_prod = 8'sd0;
    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 3'd0;
        end else if (mul_start) begin
            m_cnt  <= 3'd1;
            m_prod <= $signed(mul_a) * $signed(mul_b);
        end else if (m_cnt != 3'd0 && m_cnt < 3'd5) begin
            m_cnt <= m_cnt + 3'd1;
        end
    end
    assign mul_p = (m_cnt == 3'd5) ? m_prod : 8'hA5;

    // Event counters and protocol invariants.
    always @(negedge clk) begin
        if (!$onehot0(gnt)) viol_gnt <= viol_gnt + 1;
        if (rsp_valid && prev_rsp) viol_rsp <= viol_rsp + 1;
        prev_rsp <= rsp_valid;
        if (mul_start) start_cnt <= start_cnt + 1;
        if (gnt[3]) gnt3_cnt <= gnt3_cnt + 1;
        if (rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1;
            last_p  <= rsp_p;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic request(input int idx, input logic [3:0] a, input logic [3:0] b);
        req[idx]          = 1'b1;
        a_bus[4*idx +: 4] = a;
        b_bus[4*idx +: 4] = b;
    endtask

    // Called at a drive point; returns settled in the grant cycle (or on timeout).
    task automatic wait_gnt(output int g);
        int t;
        t = 0;
        settle();
        while (gnt == 4'b0 && t < 40) begin
            step();
            settle();
            t++;
        end
        g = cyc;
    endtask

    // Full operation for one requester; returns at the drive point of cycle g+8.
    task automatic run_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_p, input bit chk_gap);
        int g;
        int start_bad;
        int rsp_bad;
        int busy_bad;
        wait_gnt(g);
        check("gnt", 16'(gnt), 16'(1) << idx);
        if (chk_gap) check("grant_spacing", 16'(g - last_g), 16'd8);
        last_g    = g;
        start_bad = 0;
        rsp_bad   = 0;
        busy_bad  = 0;
        step();
        req[idx] = 1'b0;
        settle();
        for (int k = 1; k <= 7; k++) begin
            if (mul_start !== (k == 1)) start_bad++;
            if (rsp_valid !== (k == 7)) rsp_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (k == 1) check("mul_ab", {8'h0, mul_a, mul_b}, {8'h0, a, b});
            if (k == 7) begin
                check("rsp_id", 16'(rsp_id), 16'(idx));
                check("rsp_p", 16'(rsp_p), 16'(exp_p));
            end
            step();
            if (k < 7) settle();
        end
        check("mul_start_timing", 16'(start_bad), 16'd0);
        check("rsp_valid_timing", 16'(rsp_bad), 16'd0);
        check("busy_timing", 16'(busy_bad), 16'd0);
    endtask

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int g;
        int snap_rsp;
        int snap_start;
        int snap_gnt3;

        vecs[0] = '{1, 4'h3, 4'hE, 8'hFA};  //  3 * -2 = -6
        vecs[1] = '{0, 4'h7, 4'h8, 8'hC8};  //  7 * -8 = -56
        vecs[2] = '{2, 4'hF, 4'hF, 8'h01};  // -1 * -1 = 1
        vecs[3] = '{3, 4'hB, 4'h3, 8'hF1};  // -5 *  3 = -15
        vecs[4] = '{0, 4'h8, 4'h8, 8'h40};  // -8 * -8 = 64
        vecs[5] = '{2, 4'h0, 4'h7, 8'h00};  //  0 *  7 = 0
        vecs[6] = '{1, 4'h4, 4'h4, 8'h10};  //  4 *  4 = 16
        vecs[7] = '{3, 4'h8, 4'h7, 8'hC8};  // -8 *  7 = -56

        rst   = 1'b1;
        req   = 4'b0;
        a_bus = 16'h0;
        b_bus = 16'h0;
        step();
        step();
        rst = 1'b0;
        settle();

        // Reset state
        check("rst_gnt", 16'(gnt), 16'h0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        check("rst_mul_start", 16'(mul_start), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_rsp_id", 16'(rsp_id), 16'h0);
        check("rst_rsp_p", 16'(rsp_p), 16'h0);
        check("rst_mul_ab", {8'h0, mul_a, mul_b}, 16'h0);
        check("rst_last_ptr", 16'(dut.last_q), 16'd3);

        // All four requesting from reset: order 0,1,2,3 at 8-cycle spacing
        step();
        request(0, 4'h8, 4'h8);
        request(1, 4'h8, 4'h7);
        request(2, 4'h7, 4'h7);
        request(3, 4'h0, 4'hB);
        run_op(0, 4'h8, 4'h8, 8'h40, 1'b0);
        run_op(1, 4'h8, 4'h7, 8'hC8, 1'b1);
        run_op(2, 4'h7, 4'h7, 8'h31, 1'b1);
        run_op(3, 4'h0, 4'hB, 8'h00, 1'b1);

        // Single-requester vectors, back to back
        for (int i = 0; i < 8; i++) begin
            request(vecs[i].idx, vecs[i].a, vecs[i].b);
            run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);
        end

        // Round-robin: after 2 wins, 0101 goes to 0 first, then 2
        request(2, 4'h2, 4'h3);
        run_op(2, 4'h2, 4'h3, 8'h06, 1'b1);
        request(0, 4'h5, 4'hD);
        request(2, 4'hC, 4'h2);
        run_op(0, 4'h5, 4'hD, 8'hF1, 1'b1);
        run_op(2, 4'hC, 4'h2, 8'hF8, 1'b1);

        // Reset during WAIT aborts without a response
        snap_rsp = rsp_cnt;
        request(1, 4'h3, 4'h3);
        wait_gnt(g);
        check("rstwait_gnt", 16'(gnt), 16'b0010);
        step();
        req[1] = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("rstwait_busy", 16'(busy), 16'h0);
        check("rstwait_gnt_after", 16'(gnt), 16'h0);
        check("rstwait_state", 16'(dut.state_q), 16'h0);
        for (int k = 0; k < 6; k++) step();
        settle();
        check("rstwait_no_rsp", 16'(rsp_cnt - snap_rsp), 16'h0);
        step();
        request(3, 4'h7, 4'h9);
        run_op(3, 4'h7, 4'h9, 8'hCF, 1'b0);

        // Requester 3 withdraws during another requester's WAIT
        snap_rsp   = rsp_cnt;
        snap_start = start_cnt;
        snap_gnt3  = gnt3_cnt;
        request(0, 4'h6, 4'h6);
        wait_gnt(g);
        check("withdraw_gnt", 16'(gnt), 16'b0001);
        step();
        req[0] = 1'b0;
        step();
        step();
        request(3, 4'h1, 4'h1);
        step();
        step();
        req[3] = 1'b0;
        for (int k = 0; k < 8; k++) step();
        settle();
        check("withdraw_no_gnt3", 16'(gnt3_cnt - snap_gnt3), 16'h0);
        check("withdraw_one_start", 16'(start_cnt - snap_start), 16'd1);
        check("withdraw_one_rsp", 16'(rsp_cnt - snap_rsp), 16'd1);
        check("withdraw_rsp_p", 16'(last_p), 16'h0024);

        check("gnt_onehot_violations", 16'(viol_gnt), 16'h0);
        check("rsp_back_to_back", 16'(viol_rsp), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 4-bit signed sequential multiplier (start/a/b in, p out, fixed latency) between N requesters.
- Round-robin arbitration, req/gnt operand handshake, one-cycle tagged response.
- Sits between the requesting datapath blocks and the multiplier instance; it is the only driver of the multiplier's start and operands.

Parameters:
- N, 4, number of requesters (fixed at 4; id width is 2).
- MUL_LAT, 5, cycles from the multiplier's start-sample cycle to the first cycle its p output is valid.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  4  per-requester request level
- a_bus  in  16  signed operand a; requester i on bits [4i+3:4i]
- b_bus  in  16  signed operand b; same packing as a_bus
- gnt  out  4  one-hot, one-cycle pulse: operands of that requester latched
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  2  requester index for rsp_p
- rsp_p  out  8  signed product a*b
- busy  out  1  high in every state except IDLE
- mul_start  out  1  multiplier start, one-cycle pulse
- mul_a  out  4  multiplier operand a
- mul_b  out  4  multiplier operand b
- mul_p  in  8  multiplier product

Behaviour:
- Reset (rst high at posedge):
  - State goes to IDLE.
  - gnt, rsp_valid, mul_start and busy are 0.
  - rsp_id, rsp_p, mul_a and mul_b are 0.
  - Last-grant pointer is set to 3, so requester 0 has highest priority first.
  - The counter is cleared.
- Reset mid-operation: the operation is aborted and no response is issued. The multiplier must be reset in the same cycle; the system ties both to the same reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, choose the winner: the first set bit searching upward (wrapping) from last+1.
  - Pulse gnt[winner] this cycle.
  - Latch the winner's operands into mul_a/mul_b, its id into an id register, and update last := winner.
  - Next state is ISSUE.
  - If no req bit is set, stay in IDLE; gnt stays 0.
- ISSUE: mul_start=1 for exactly this cycle; cnt := 0; next state is WAIT.
- WAIT:
  - cnt increments each cycle.
  - In the cycle where cnt == MUL_LAT-1, register mul_p into rsp_p and go to RESP.
  - WAIT lasts MUL_LAT cycles.
- RESP: rsp_valid=1 for one cycle with rsp_id and rsp_p; next state is IDLE.
- Timing:
  - Grant cycle g, ISSUE g+1, WAIT g+2..g+6, RESP g+7, IDLE g+8.
  - Minimum spacing between grants is 8 cycles.
  - The IDLE cycle after RESP guarantees the multiplier has returned to its idle state before the next start.
- rsp_p and rsp_id hold their last values after RESP; they are valid only while rsp_valid is high.
- mul_a/mul_b are held from grant until the next grant.
- Requester contract:
  - Hold req high and the operands stable until gnt is seen; drop req in the cycle after gnt unless another operation is wanted.
  - req sampled high in the cycle after its own gnt counts as a new request.
- A requester that drops req before being granted receives no grant.
- req changes while not in IDLE are ignored; arbitration happens only in IDLE.
- Product is the full 8-bit signed product. -8*-8=+64 must be correct (8'h40).
- gnt is one-hot or zero. rsp_valid is never high in two consecutive cycles.

Test Plan:
- Single request, operands 3 and -2:
  - Stimulus: after reset, req=4'b0010, a_bus[7:4]=3, b_bus[7:4]=-2, held until gnt.
  - Response: gnt=4'b0010 at cycle g; mul_start high only at g+1; rsp_valid at g+7 with rsp_id=1 and rsp_p=8'hFA (-6).
- All four requesting from reset:
  - Stimulus: req=4'b1111 from reset, each held until its gnt; operand pairs (-8,-8), (-8,7), (7,7), (0,-5).
  - Response: grants in order 0,1,2,3 at g, g+8, g+16, g+24; results 8'h40, 8'hC8, 8'h31, 8'h00 with matching ids.
- Round-robin fairness:
  - Stimulus: requester 2 is granted; then req=4'b0101 is presented.
  - Response: next grant goes to 0 (search starts at 3 and wraps), then to 2.
- Reset during WAIT:
  - Stimulus: assert rst in cycle g+4, then release it.
  - Response: no rsp_valid; the following cycle shows busy=0, gnt=0 and state IDLE; a new request is served normally with correct timing.
- Early request withdrawal:
  - Stimulus: requester 3 raises req during another requester's WAIT, then drops it before IDLE.
  - Response: gnt[3] never asserts; no extra mul_start.
